// File: rtl/atomic_unit.sv
// Atomic read-modify-write engine: services one ADD/EXCH/CAS/AND request at a
// time against a single-port memory, with retire and failed-CAS counters.
module atomic_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              atomic_request,
  input  logic [1:0]        atomic_op,
  input  logic [ADDR_W-1:0] atomic_address,
  input  logic [DATA_W-1:0] atomic_data,
  input  logic [DATA_W-1:0] atomic_compare,
  output logic              atomic_ready,
  output logic [DATA_W-1:0] atomic_result,
  output logic              atomic_error,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       ops_completed,
  output logic [15:0]       cas_fail_count
);

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned CAS_CNT_W = 16;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_EXCH = 2'd1;
  localparam logic [1:0] OP_CAS  = 2'd2;
  localparam logic [1:0] OP_AND  = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_MODIFY = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cmp_q;
  logic [DATA_W-1:0] old_q;

  logic [DATA_W-1:0] new_val;
  logic [ADDR_W-1:0] addr_cur;
  logic              cas_fail;
  logic              mem_req_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and modify datapath
  always_comb begin
    state_next = state;
    new_val    = old_q;
    cas_fail   = 1'b0;
    addr_cur   = addr_q;
    case (state)
      S_IDLE: begin
        addr_cur = atomic_address;
        if (atomic_request)
          state_next = (atomic_address[1:0] != 2'b00) ? S_DONE : S_READ;
      end
      S_READ: if (mem_ack) state_next = S_MODIFY;
      S_MODIFY: begin
        case (op_q)
          OP_ADD:  new_val = old_q + data_q;
          OP_EXCH: new_val = data_q;
          OP_AND:  new_val = old_q & data_q;
          OP_CAS:  new_val = data_q;
          default: new_val = old_q;
        endcase
        cas_fail   = (op_q == OP_CAS) && (old_q != cmp_q);
        state_next = cas_fail ? S_DONE : S_WRITE;
      end
      S_WRITE: if (mem_ack) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign mem_req_next = (state_next == S_READ) || (state_next == S_WRITE);

  // Request capture; old value cleared at accept so a misaligned retire reports 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'd0;
      addr_q <= '0;
      data_q <= '0;
      cmp_q  <= '0;
      old_q  <= '0;
    end else begin
      if (state == S_IDLE && atomic_request) begin
        op_q   <= atomic_op;
        addr_q <= atomic_address;
        data_q <= atomic_data;
        cmp_q  <= atomic_compare;
        old_q  <= '0;
      end
      if (state == S_READ && mem_ack) old_q <= mem_rdata;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      atomic_ready   <= 1'b0;
      atomic_error   <= 1'b0;
      atomic_result  <= '0;
      busy           <= 1'b0;
      ops_completed  <= '0;
      cas_fail_count <= '0;
    end else begin
      mem_req      <= mem_req_next;
      mem_we       <= (state_next == S_WRITE);
      mem_addr     <= mem_req_next ? addr_cur : '0;
      if (state_next == S_WRITE)
        mem_wdata <= (state == S_MODIFY) ? new_val : mem_wdata;
      else
        mem_wdata <= '0;
      atomic_ready  <= (state_next == S_DONE);
      atomic_error  <= (state == S_IDLE) && (state_next == S_DONE);
      atomic_result <= (state_next == S_DONE && state != S_IDLE) ? old_q : '0;
      busy          <= (state_next != S_IDLE);
      if (state_next == S_DONE)
        ops_completed <= ops_completed + CNT_W'(1);
      if (cas_fail && cas_fail_count != 16'hFFFF)
        cas_fail_count <= cas_fail_count + CAS_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_atomic_unit.sv
// Directed bench for atomic_unit with a word-addressed memory responder of
// programmable ack latency.
module tb_atomic_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              atomic_request;
  logic [1:0]        atomic_op;
  logic [ADDR_W-1:0] atomic_address;
  logic [DATA_W-1:0] atomic_data;
  logic [DATA_W-1:0] atomic_compare;
  logic              atomic_ready;
  logic [DATA_W-1:0] atomic_result;
  logic              atomic_error;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [31:0]       ops_completed;
  logic [15:0]       cas_fail_count;

  int checks = 0;
  int fails  = 0;

  // Memory model controls and observations
  logic [31:0] mem [256];
  int          delay     = 0;
  logic        wr_ack_en = 1'b1;
  logic        ack_force = 1'b0;
  logic        pre_en    = 1'b0;
  logic [7:0]  pre_idx   = 8'd0;
  logic [31:0] pre_val   = 32'd0;
  logic        clr       = 1'b0;
  int          wait_cnt  = 0;
  int          reads, writes, req_cycles, ready_cnt, unstable;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr, prev_wdata;

  atomic_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .atomic_request(atomic_request), .atomic_op(atomic_op),
    .atomic_address(atomic_address), .atomic_data(atomic_data),
    .atomic_compare(atomic_compare), .atomic_ready(atomic_ready),
    .atomic_result(atomic_result), .atomic_error(atomic_error),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ops_completed(ops_completed), .cas_fail_count(cas_fail_count)
  );

  always #5 clk = ~clk;

  assign mem_ack   = ack_force ||
                     (mem_req && (wait_cnt >= delay) && (!mem_we || wr_ack_en));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr[9:2]] <= mem_wdata;
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    if (clr) begin
      reads <= 0; writes <= 0; req_cycles <= 0; ready_cnt <= 0; unstable <= 0;
      last_rd_addr <= 32'd0; last_wr_addr <= 32'd0; last_wr_data <= 32'd0;
    end else begin
      if (mem_req) req_cycles <= req_cycles + 1;
      if (atomic_ready) ready_cnt <= ready_cnt + 1;
      if (mem_req && mem_ack && !mem_we) begin
        reads <= reads + 1; last_rd_addr <= mem_addr;
      end
      if (mem_req && mem_ack && mem_we) begin
        writes <= writes + 1; last_wr_addr <= mem_addr; last_wr_data <= mem_wdata;
      end
      if (prev_req && !prev_ack &&
          (!mem_req || mem_addr != prev_addr || mem_wdata != prev_wdata))
        unstable <= unstable + 1;
    end
    prev_req <= mem_req; prev_ack <= mem_ack;
    prev_addr <= mem_addr; prev_wdata <= mem_wdata;
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = addr[9:2]; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Issue one request at a negedge; lat counts rising edges from accept to ready (-1 on timeout)
  task automatic do_op(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] cmp,
                       input bit drop_early, output int lat,
                       output logic [31:0] res, output logic err);
    bit got = 0;
    clear_stats();
    atomic_op = op; atomic_address = addr; atomic_data = data;
    atomic_compare = cmp; atomic_request = 1'b1;
    lat = 0; res = 32'hDEAD_BEEF; err = 1'bx;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (drop_early) atomic_request = 1'b0;
      if (atomic_ready) begin
        res = atomic_result; err = atomic_error; got = 1;
        break;
      end
    end
    atomic_request = 1'b0;
    if (!got) lat = -1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; atomic_request = 1'b0; atomic_op = 2'd0;
    atomic_address = 32'd0; atomic_data = 32'd0; atomic_compare = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, mem_req, mem_we, atomic_ready, atomic_error} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000",
                        {busy, mem_req, mem_we, atomic_ready, atomic_error});
    end
    checks++;
    if (ops_completed !== 32'd0 || cas_fail_count !== 16'd0 ||
        atomic_result !== 32'd0 || mem_addr !== 32'd0) begin
      fails++; $display("FAIL reset_data: ops=%0h cas=%0h res=%0h addr=%0h expected all 0",
                        ops_completed, cas_fail_count, atomic_result, mem_addr);
    end
    @(negedge clk); rst = 1'b0; clr = 1'b0;
  endtask

  task automatic test_add();
    int lat; logic [31:0] res; logic err;
    preload(32'h100, 32'd5);
    do_op(2'd0, 32'h100, 32'd3, 32'd0, 1'b0, lat, res, err);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL add_latency: got %0d expected 4", lat); end
    checks++;
    if (res !== 32'd5 || err !== 1'b0) begin
      fails++; $display("FAIL add_result: got %0h err=%b expected 5 err=0", res, err);
    end
    checks++;
    if (mem[8'h40] !== 32'd8 || last_rd_addr !== 32'h100 || last_wr_addr !== 32'h100) begin
      fails++; $display("FAIL add_memory: mem=%0h rd=%0h wr=%0h expected 8 100 100",
                        mem[8'h40], last_rd_addr, last_wr_addr);
    end
    checks++;
    if (ops_completed !== 32'd1 || ready_cnt !== 1) begin
      fails++; $display("FAIL add_ops: ops=%0d pulses=%0d expected 1 1", ops_completed, ready_cnt);
    end
  endtask

  task automatic test_cas();
    int lat; logic [31:0] res; logic err;
    preload(32'h40, 32'd7);
    do_op(2'd2, 32'h40, 32'd9, 32'd6, 1'b0, lat, res, err);
    checks++;
    if (lat !== 3 || res !== 32'd7) begin
      fails++; $display("FAIL cas_fail_timing: lat=%0d res=%0h expected 3 7", lat, res);
    end
    checks++;
    if (writes !== 0 || mem[8'h10] !== 32'd7 || cas_fail_count !== 16'd1) begin
      fails++; $display("FAIL cas_fail_effect: writes=%0d mem=%0h cas=%0d expected 0 7 1",
                        writes, mem[8'h10], cas_fail_count);
    end
    do_op(2'd2, 32'h40, 32'd9, 32'd7, 1'b0, lat, res, err);
    checks++;
    if (lat !== 4 || res !== 32'd7 || mem[8'h10] !== 32'd9) begin
      fails++; $display("FAIL cas_success: lat=%0d res=%0h mem=%0h expected 4 7 9",
                        lat, res, mem[8'h10]);
    end
    checks++;
    if (cas_fail_count !== 16'd1 || ops_completed !== 32'd3) begin
      fails++; $display("FAIL cas_counters: cas=%0d ops=%0d expected 1 3",
                        cas_fail_count, ops_completed);
    end
  endtask

  task automatic test_add_wrap();
    int lat; logic [31:0] res; logic err;
    preload(32'h80, 32'hFFFF_FFFF);
    do_op(2'd0, 32'h80, 32'd2, 32'd0, 1'b0, lat, res, err);
    checks++;
    if (res !== 32'hFFFF_FFFF || mem[8'h20] !== 32'h1 || last_wr_data !== 32'h1) begin
      fails++; $display("FAIL add_wrap: res=%0h mem=%0h wdata=%0h expected ffffffff 1 1",
                        res, mem[8'h20], last_wr_data);
    end
  endtask

  task automatic test_exch_and();
    int lat; logic [31:0] res; logic err;
    preload(32'h10, 32'hA5);
    do_op(2'd1, 32'h10, 32'h5A, 32'd0, 1'b0, lat, res, err);
    checks++;
    if (res !== 32'hA5 || mem[8'h04] !== 32'h5A) begin
      fails++; $display("FAIL exch: res=%0h mem=%0h expected a5 5a", res, mem[8'h04]);
    end
    preload(32'h14, 32'h0000_F0F0);
    do_op(2'd3, 32'h14, 32'h0000_FF00, 32'd0, 1'b0, lat, res, err);
    checks++;
    if (res !== 32'hF0F0 || mem[8'h05] !== 32'hF000 || lat !== 4) begin
      fails++; $display("FAIL and: res=%0h mem=%0h lat=%0d expected f0f0 f000 4",
                        res, mem[8'h05], lat);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] res; logic err;
    logic [31:0] ops_before;
    ops_before = ops_completed;
    do_op(2'd1, 32'h102, 32'h1234, 32'd0, 1'b0, lat, res, err);
    checks++;
    if (lat !== 1 || err !== 1'b1 || res !== 32'd0) begin
      fails++; $display("FAIL misaligned: lat=%0d err=%b res=%0h expected 1 1 0", lat, err, res);
    end
    checks++;
    if (req_cycles !== 0 || ops_completed !== ops_before + 32'd1 || atomic_error !== 1'b0) begin
      fails++; $display("FAIL misaligned_side: reqs=%0d ops=%0d err_after=%b expected 0 %0d 0",
                        req_cycles, ops_completed, atomic_error, ops_before + 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1, lat2 = -1;
    logic [31:0] res2 = 32'hDEAD_BEEF;
    preload(32'h20, 32'd10);
    clear_stats();
    atomic_op = 2'd0; atomic_address = 32'h20; atomic_data = 32'd1; atomic_request = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (atomic_ready) begin lat1 = i; break; end
    end
    atomic_data = 32'd5;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (atomic_ready) begin lat2 = i; res2 = atomic_result; break; end
    end
    atomic_request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lat1 !== 4 || lat2 !== 5 || res2 !== 32'd11) begin
      fails++; $display("FAIL back_to_back: lat1=%0d lat2=%0d res2=%0d expected 4 5 11",
                        lat1, lat2, res2);
    end
    checks++;
    if (mem[8'h08] !== 32'd16 || ready_cnt !== 2) begin
      fails++; $display("FAIL back_to_back_mem: mem=%0d pulses=%0d expected 16 2",
                        mem[8'h08], ready_cnt);
    end
  endtask

  task automatic test_delay();
    int lat; logic [31:0] res; logic err;
    delay = 3;
    preload(32'h30, 32'd100);
    do_op(2'd0, 32'h30, 32'd20, 32'd0, 1'b1, lat, res, err);
    checks++;
    if (lat !== 10 || res !== 32'd100 || mem[8'h0C] !== 32'd120) begin
      fails++; $display("FAIL delay_op: lat=%0d res=%0d mem=%0d expected 10 100 120",
                        lat, res, mem[8'h0C]);
    end
    checks++;
    if (unstable !== 0 || ready_cnt !== 1 || req_cycles !== 8) begin
      fails++; $display("FAIL delay_stable: unstable=%0d pulses=%0d reqs=%0d expected 0 1 8",
                        unstable, ready_cnt, req_cycles);
    end
    delay = 0;
  endtask

  task automatic test_reset_write();
    bit saw_we = 0;
    wr_ack_en = 1'b0;
    preload(32'h50, 32'd40);
    clear_stats();
    atomic_op = 2'd1; atomic_address = 32'h50; atomic_data = 32'd77; atomic_request = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_we) begin saw_we = 1; break; end
    end
    atomic_request = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!saw_we || mem_req !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL reset_in_write: saw_we=%0b req=%b busy=%b we=%b expected 1 0 0 0",
                        saw_we, mem_req, busy, mem_we);
    end
    checks++;
    if (ops_completed !== 32'd0 || cas_fail_count !== 16'd0) begin
      fails++; $display("FAIL reset_counters: ops=%0d cas=%0d expected 0 0",
                        ops_completed, cas_fail_count);
    end
    @(negedge clk); rst = 1'b0; wr_ack_en = 1'b1; ack_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); ack_force = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready_cnt !== 0 || mem[8'h14] !== 32'd40 || ops_completed !== 32'd0) begin
      fails++; $display("FAIL stray_ack: busy=%b pulses=%0d mem=%0d ops=%0d expected 0 0 40 0",
                        busy, ready_cnt, mem[8'h14], ops_completed);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cas();
    test_add_wrap();
    test_exch_and();
    test_misaligned();
    test_back_to_back();
    test_delay();
    test_reset_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
